// File: rtl/data_bus_responder_pkg.sv
// Shared address map, status-bit positions and UART transmitter state encoding
// for the data bus responder.
package data_bus_responder_pkg;

  localparam logic [31:0] UART_DATA_ADDR = 32'h1000_0000;
  localparam logic [31:0] UART_STAT_ADDR = 32'h1000_0004;
  localparam logic [31:0] LED_ADDR       = 32'h1000_0008;
  localparam logic [31:0] CYC_LO_ADDR    = 32'h1000_000C;
  localparam logic [31:0] CYC_HI_ADDR    = 32'h1000_0010;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_FULL_BIT = 1;
  localparam int STAT_OVF_BIT  = 2;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  function automatic logic word_match(input logic [31:0] addr, input logic [31:0] reg_addr);
    return addr[31:2] == reg_addr[31:2];
  endfunction

endpackage

// File: rtl/data_bus_responder_tx_fifo.sv
// 4-entry x 8-bit FIFO feeding the UART transmitter; a push into a full FIFO
// is accepted when a pop happens on the same edge.
module data_bus_responder_tx_fifo (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);

  logic [7:0] mem_q [4];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic       pop_ok, push_ok;

  assign full     = count_q == 3'd4;
  assign empty    = count_q == 3'd0;
  assign pop_data = mem_q[rd_ptr_q];
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 2'd1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 2'd1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage arrays carry no reset; emptiness is tracked by count_q alone.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/data_bus_responder.sv
// Data-port responder: word RAM, UART transmitter with FIFO, LED register and
// 64-bit cycle counter, all decoded from the core's load/store bus.
module data_bus_responder
  import data_bus_responder_pkg::*;
#(
  parameter int RAM_WORDS = 1024,
  parameter int CLK_DIV   = 434,
  parameter int LED_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 store,
  input  logic [31:0]          address,
  input  logic [31:0]          store_data,
  output logic [31:0]          load_data,
  output logic                 uart_tx,
  output logic [LED_WIDTH-1:0] leds
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int TW     = $clog2(CLK_DIV);
  localparam logic [TW-1:0] BIT_LAST = TW'(CLK_DIV - 1);

  logic [31:0] ram_q [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx;
  logic ram_hit, sel_uart_data, sel_stat, sel_led, sel_cyc_lo, sel_cyc_hi;
  logic [1:0] unused_addr_bits;

  assign ram_idx          = address[RAM_AW+1:2];
  assign ram_hit          = address[31:RAM_AW+2] == '0;
  assign sel_uart_data    = word_match(address, UART_DATA_ADDR);
  assign sel_stat         = word_match(address, UART_STAT_ADDR);
  assign sel_led          = word_match(address, LED_ADDR);
  assign sel_cyc_lo       = word_match(address, CYC_LO_ADDR);
  assign sel_cyc_hi       = word_match(address, CYC_HI_ADDR);
  assign unused_addr_bits = address[1:0];

  always_ff @(posedge clock) begin
    if (store && ram_hit) ram_q[ram_idx] <= store_data;
  end

  logic [LED_WIDTH-1:0] leds_q, leds_d;
  logic [63:0]          cyc_q, cyc_d;
  logic                 ovf_q, ovf_d;
  tx_state_e            state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [7:0]           shift_q, shift_d;
  logic                 tx_q, tx_d;

  logic       fifo_push, fifo_pop, fifo_full, fifo_empty, push_drop, busy, timer_done;
  logic [7:0] fifo_data;
  logic [31:0] stat_word;

  assign fifo_push  = store && sel_uart_data;
  assign push_drop  = fifo_push && fifo_full && !fifo_pop;
  assign busy       = (state_q != TX_IDLE) || !fifo_empty;
  assign timer_done = timer_q == '0;

  data_bus_responder_tx_fifo u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (store_data[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    stat_word                = '0;
    stat_word[STAT_BUSY_BIT] = busy;
    stat_word[STAT_FULL_BIT] = fifo_full;
    stat_word[STAT_OVF_BIT]  = ovf_q;

    load_data = '0;
    if (load) begin
      if (ram_hit)         load_data = ram_q[ram_idx];
      else if (sel_stat)   load_data = stat_word;
      else if (sel_led)    load_data = 32'(leds_q);
      else if (sel_cyc_lo) load_data = cyc_q[31:0];
      else if (sel_cyc_hi) load_data = cyc_q[63:32];
    end

    leds_d = leds_q;
    if (store && sel_led) leds_d = store_data[LED_WIDTH-1:0];

    cyc_d = cyc_q + 64'd1;

    // Set wins over the read-clear when both land on the same edge.
    ovf_d = ovf_q;
    if (load && sel_stat) ovf_d = 1'b0;
    if (push_drop)        ovf_d = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    fifo_pop  = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_data;
          timer_d  = BIT_LAST;
          tx_d     = 1'b0;
          state_d  = TX_START;
        end
      end
      TX_START: begin
        if (timer_done) begin
          timer_d   = BIT_LAST;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
          state_d   = TX_DATA;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      TX_DATA: begin
        if (timer_done) begin
          timer_d = BIT_LAST;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = TX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      TX_STOP: begin
        if (!timer_done) begin
          timer_d = timer_q - 1'b1;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_data;
          timer_d  = BIT_LAST;
          tx_d     = 1'b0;
          state_d  = TX_START;
        end else begin
          tx_d    = 1'b1;
          state_d = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge clock) begin
    if (!reset) begin
      leds_q    <= '0;
      cyc_q     <= '0;
      ovf_q     <= 1'b0;
      state_q   <= TX_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      leds_q    <= leds_d;
      cyc_q     <= cyc_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  assign uart_tx = tx_q;
  assign leds    = leds_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder: table of bus vectors plus hand-written
// UART, overflow, reset and cycle-counter sequences.
module tb_data_bus_responder;

  localparam logic [31:0] A_UDATA = 32'h1000_0000;
  localparam logic [31:0] A_STAT  = 32'h1000_0004;
  localparam logic [31:0] A_LED   = 32'h1000_0008;
  localparam logic [31:0] A_CYCLO = 32'h1000_000C;
  localparam logic [31:0] A_CYCHI = 32'h1000_0010;

  logic        clock = 1'b0;
  logic        reset, load, store;
  logic [31:0] address, store_data, load_data;
  logic        uart_tx;
  logic [7:0]  leds;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] rx_q [$];

  data_bus_responder #(.RAM_WORDS(64), .CLK_DIV(4), .LED_WIDTH(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .store      (store),
    .address    (address),
    .store_data (store_data),
    .load_data  (load_data),
    .uart_tx    (uart_tx),
    .leds       (leds)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        ld;
    logic        st;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [7:0]  exp_leds;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Serial receiver: sample each bit in mid-cell (CLK_DIV=4, sampled on negedges).
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clock);
      if (reset === 1'b1 && uart_tx === 1'b0) begin
        repeat (5) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
          b[i] = uart_tx;
          if (i < 7) repeat (4) @(negedge clock);
        end
        rx_q.push_back(b);
        repeat (4) @(negedge clock);
      end
    end
  end

  task automatic drive(input logic ld, input logic st, input logic [31:0] a, input logic [31:0] d);
    load = ld; store = st; address = a; store_data = d;
  endtask

  task automatic wait_idle(input string name);
    logic idle = 1'b0;
    for (int i = 0; i < 1000 && !idle; i++) begin
      @(negedge clock);
      drive(1'b1, 1'b0, A_STAT, 32'd0);
      #1;
      idle = (load_data[0] == 1'b0);
    end
    check(name, {63'd0, idle}, 64'd1);
    drive(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  vec_t vecs [17];
  logic exp_tx;

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 32'h40,        32'hDEADBEEF, 32'h0,        8'h00};
    vecs[1]  = '{1'b1, 1'b0, 32'h40,        32'h0,        32'hDEADBEEF, 8'h00};
    vecs[2]  = '{1'b0, 1'b0, 32'h40,        32'h0,        32'h0,        8'h00};
    vecs[3]  = '{1'b1, 1'b1, 32'h40,        32'h12345678, 32'hDEADBEEF, 8'h00};
    vecs[4]  = '{1'b1, 1'b0, 32'h40,        32'h0,        32'h12345678, 8'h00};
    vecs[5]  = '{1'b1, 1'b0, 32'h43,        32'h0,        32'h12345678, 8'h00};
    vecs[6]  = '{1'b0, 1'b1, A_LED,         32'h1A5,      32'h0,        8'h00};
    vecs[7]  = '{1'b1, 1'b0, A_LED,         32'h0,        32'h000000A5, 8'hA5};
    vecs[8]  = '{1'b0, 1'b1, 32'h2000_0000, 32'hCAFEF00D, 32'h0,        8'hA5};
    vecs[9]  = '{1'b1, 1'b0, 32'h2000_0000, 32'h0,        32'h0,        8'hA5};
    vecs[10] = '{1'b1, 1'b0, A_LED,         32'h0,        32'h000000A5, 8'hA5};
    vecs[11] = '{1'b1, 1'b0, 32'h40,        32'h0,        32'h12345678, 8'hA5};
    vecs[12] = '{1'b0, 1'b1, 32'hFC,        32'h0BADF00D, 32'h0,        8'hA5};
    vecs[13] = '{1'b1, 1'b0, 32'hFC,        32'h0,        32'h0BADF00D, 8'hA5};
    vecs[14] = '{1'b1, 1'b0, 32'h100,       32'h0,        32'h0,        8'hA5};
    vecs[15] = '{1'b1, 1'b1, A_LED,         32'h77,       32'h000000A5, 8'hA5};
    vecs[16] = '{1'b1, 1'b0, A_LED,         32'h0,        32'h00000077, 8'h77};

    reset = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("reset_uart_tx", {63'd0, uart_tx}, 64'd1);
    check("reset_leds", {56'd0, leds}, 64'd0);
    drive(1'b1, 1'b0, A_STAT, 32'd0);
    #1;
    check("reset_stat", {32'd0, load_data}, 64'd0);

    for (int i = 0; i < 17; i++) begin
      @(negedge clock);
      drive(vecs[i].ld, vecs[i].st, vecs[i].addr, vecs[i].wdata);
      #1;
      check($sformatf("vec%0d_load_data", i), {32'd0, load_data}, {32'd0, vecs[i].exp_rd});
      check($sformatf("vec%0d_leds", i), {56'd0, leds}, {56'd0, vecs[i].exp_leds});
    end

    // Single byte 0x55: 1 queued cycle, 4 start, 8x4 data, 4 stop, then idle.
    @(negedge clock);
    drive(1'b0, 1'b1, A_UDATA, 32'h55);
    for (int k = 1; k <= 42; k++) begin
      @(negedge clock);
      drive(1'b1, 1'b0, A_STAT, 32'd0);
      #1;
      if (k == 1 || k >= 38)  exp_tx = 1'b1;
      else if (k <= 5)        exp_tx = 1'b0;
      else                    exp_tx = 1'((8'h55 >> ((k - 6) / 4)) & 8'h1);
      check($sformatf("frame55_tx_k%0d", k), {63'd0, uart_tx}, {63'd0, exp_tx});
      check($sformatf("frame55_busy_k%0d", k), {63'd0, load_data[0]}, {63'd0, (k <= 41)});
    end
    wait_idle("frame55_drain");
    check("frame55_rx_count", 64'(rx_q.size()), 64'd1);
    if (rx_q.size() > 0) check("frame55_rx_byte", {56'd0, rx_q[0]}, 64'h55);
    rx_q.delete();

    // Six back-to-back pushes: first popped, four queued, sixth dropped.
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      drive(1'b0, 1'b1, A_UDATA, 32'hA0 + 32'(i));
    end
    @(negedge clock);
    drive(1'b1, 1'b0, A_STAT, 32'd0);
    #1;
    check("ovf_stat_before_clear", {32'd0, load_data}, 64'h7);
    @(negedge clock);
    #1;
    check("ovf_stat_after_clear", {32'd0, load_data}, 64'h3);
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    wait_idle("ovf_drain");
    repeat (2) @(negedge clock);
    check("ovf_rx_count", 64'(rx_q.size()), 64'd5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++)
      check($sformatf("ovf_rx_byte%0d", i), {56'd0, rx_q[i]}, 64'hA0 + 64'(i));

    // Reset mid-frame aborts transmission and clears LEDs.
    @(negedge clock);
    drive(1'b0, 1'b1, A_UDATA, 32'h3C);
    @(negedge clock);
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (9) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    #1;
    check("midframe_reset_tx", {63'd0, uart_tx}, 64'd1);
    check("midframe_reset_leds", {56'd0, leds}, 64'd0);
    drive(1'b1, 1'b0, A_STAT, 32'd0);
    #1;
    check("midframe_reset_stat", {32'd0, load_data}, 64'd0);
    reset = 1'b1;
    @(negedge clock);
    #1;
    check("after_reset_tx_idle", {63'd0, uart_tx}, 64'd1);
    drive(1'b0, 1'b0, 32'd0, 32'd0);

    // Cycle counter: one reset cycle, ten running cycles.
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (10) @(negedge clock);
    drive(1'b1, 1'b0, A_CYCLO, 32'd0);
    #1;
    check("cyc_lo_after_10", {32'd0, load_data}, 64'd10);
    drive(1'b1, 1'b0, A_CYCHI, 32'd0);
    #1;
    check("cyc_hi_after_10", {32'd0, load_data}, 64'd0);

    @(negedge clock);
    force dut.cyc_q = 64'hFFFF_FFFF_FFFF_FFFF;
    drive(1'b1, 1'b0, A_CYCLO, 32'd0);
    #1;
    check("cyc_lo_max", {32'd0, load_data}, 64'hFFFF_FFFF);
    drive(1'b1, 1'b0, A_CYCHI, 32'd0);
    #1;
    check("cyc_hi_max", {32'd0, load_data}, 64'hFFFF_FFFF);
    release dut.cyc_q;
    @(negedge clock);
    #1;
    check("cyc_hi_wrap", {32'd0, load_data}, 64'd0);
    drive(1'b1, 1'b0, A_CYCLO, 32'd0);
    #1;
    check("cyc_lo_wrap", {32'd0, load_data}, 64'd0);
    drive(1'b0, 1'b0, 32'd0, 32'd0);

    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
